// File: rtl/div_unit_pkg.sv
// Shared divider definitions: operation codes, FSM state encoding and an
// operation decoder. The ALU and instruction decoder import the same codes.
package div_unit_pkg;

  localparam int unsigned OP_W = 5;

  // Division/remainder operation codes
  localparam logic [OP_W-1:0] OP_DIV   = 5'b10011;
  localparam logic [OP_W-1:0] OP_DIVU  = 5'b10100;
  localparam logic [OP_W-1:0] OP_REM   = 5'b10101;
  localparam logic [OP_W-1:0] OP_REMU  = 5'b10110;
  localparam logic [OP_W-1:0] OP_DIVW  = 5'b11000;
  localparam logic [OP_W-1:0] OP_DIVUW = 5'b11001;
  localparam logic [OP_W-1:0] OP_REMW  = 5'b11010;
  localparam logic [OP_W-1:0] OP_REMUW = 5'b11011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

  // Decoded operation attributes
  typedef struct packed {
    logic valid;  // code is a divider operation
    logic word;   // 32-bit (*W) operation
    logic sgn;    // signed operation
    logic rem;    // remainder (vs quotient) result
  } div_op_t;

  function automatic div_op_t decode_op(input logic [OP_W-1:0] code);
    div_op_t op;
    op = '0;
    case (code)
      OP_DIV:   op = '{valid: 1'b1, word: 1'b0, sgn: 1'b1, rem: 1'b0};
      OP_DIVU:  op = '{valid: 1'b1, word: 1'b0, sgn: 1'b0, rem: 1'b0};
      OP_REM:   op = '{valid: 1'b1, word: 1'b0, sgn: 1'b1, rem: 1'b1};
      OP_REMU:  op = '{valid: 1'b1, word: 1'b0, sgn: 1'b0, rem: 1'b1};
      OP_DIVW:  op = '{valid: 1'b1, word: 1'b1, sgn: 1'b1, rem: 1'b0};
      OP_DIVUW: op = '{valid: 1'b1, word: 1'b1, sgn: 1'b0, rem: 1'b0};
      OP_REMW:  op = '{valid: 1'b1, word: 1'b1, sgn: 1'b1, rem: 1'b1};
      OP_REMUW: op = '{valid: 1'b1, word: 1'b1, sgn: 1'b0, rem: 1'b1};
      default:  op = '0;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring radix-2 integer divider (one quotient bit per cycle).
// Ports:
//   i_clk, i_arst_n        clock, asynchronous active-low reset
//   i_start, i_flush       begin a division / abandon the current one
//   i_alu_control          operation code (see div_unit_pkg)
//   i_src_1, i_src_2       dividend, divisor
//   o_busy                 operation held (state != IDLE)
//   o_done                 one-cycle result-valid pulse
//   o_result               registered quotient or remainder, held until next done
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned WORD_WIDTH    = 32,
  parameter int unsigned CONTROL_WIDTH = 5
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic                     i_start,
  input  logic                     i_flush,
  input  logic [CONTROL_WIDTH-1:0] i_alu_control,
  input  logic [DATA_WIDTH-1:0]    i_src_1,
  input  logic [DATA_WIDTH-1:0]    i_src_2,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [DATA_WIDTH-1:0]    o_result
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam int unsigned PAD_W = DATA_WIDTH - WORD_WIDTH;
  localparam logic [DATA_WIDTH-1:0] MIN_FULL = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [WORD_WIDTH-1:0] MIN_WORD = {1'b1, {(WORD_WIDTH-1){1'b0}}};

  function automatic logic [DATA_WIDTH-1:0] sext_word(input logic [WORD_WIDTH-1:0] x);
    return {{PAD_W{x[WORD_WIDTH-1]}}, x};
  endfunction

  div_state_t state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;   // dividend shifting out, quotient shifting in
  logic [DATA_WIDTH-1:0] rem_q, rem_d;   // partial remainder
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;   // divisor magnitude
  logic                  word_q, word_d;
  logic                  is_rem_q, is_rem_d;
  logic                  neg_q_q, neg_q_d;
  logic                  neg_r_q, neg_r_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;

  div_op_t               op_c;
  logic [WORD_WIDTH-1:0] a_w, b_w, a_w_mag, b_w_mag;
  logic [DATA_WIDTH-1:0] a_f_mag, b_f_mag, a_ext, load_quo, load_dvs, special_res;
  logic                  a_neg, b_neg, div_zero, ovf;

  // Operand preparation and special-case detection at accept
  always_comb begin : prep
    op_c     = decode_op(OP_W'(i_alu_control));
    a_w      = i_src_1[WORD_WIDTH-1:0];
    b_w      = i_src_2[WORD_WIDTH-1:0];
    a_neg    = op_c.sgn & (op_c.word ? a_w[WORD_WIDTH-1] : i_src_1[DATA_WIDTH-1]);
    b_neg    = op_c.sgn & (op_c.word ? b_w[WORD_WIDTH-1] : i_src_2[DATA_WIDTH-1]);
    a_w_mag  = a_neg ? -a_w : a_w;
    b_w_mag  = b_neg ? -b_w : b_w;
    a_f_mag  = a_neg ? -i_src_1 : i_src_1;
    b_f_mag  = b_neg ? -i_src_2 : i_src_2;
    div_zero = op_c.word ? (b_w == '0) : (i_src_2 == '0);
    ovf      = op_c.sgn & (op_c.word ? ((a_w == MIN_WORD) && (b_w == '1))
                                     : ((i_src_1 == MIN_FULL) && (i_src_2 == '1)));
    // Word dividends sit at the top so 32 shifts consume them entirely
    load_quo = op_c.word ? {a_w_mag, {PAD_W{1'b0}}} : a_f_mag;
    load_dvs = op_c.word ? {{PAD_W{1'b0}}, b_w_mag} : b_f_mag;
    a_ext    = op_c.word ? sext_word(a_w) : i_src_1;
    if (div_zero) begin
      special_res = op_c.rem ? a_ext : '1;
    end else begin
      special_res = op_c.rem ? '0 : a_ext;
    end
  end

  logic [DATA_WIDTH:0]   rem_ext, diff;
  logic                  ge;
  logic [DATA_WIDTH-1:0] step_quo, step_rem, q_full, r_full, final_res;
  logic [WORD_WIDTH-1:0] q_word, r_word;
  logic [CNT_W-1:0]      cnt_last;

  // One restoring step plus sign fix-up of the final quotient/remainder
  always_comb begin : step
    rem_ext   = {rem_q, quo_q[DATA_WIDTH-1]};
    diff      = rem_ext - {1'b0, dvs_q};
    ge        = ~diff[DATA_WIDTH];
    step_rem  = ge ? diff[DATA_WIDTH-1:0] : rem_ext[DATA_WIDTH-1:0];
    step_quo  = {quo_q[DATA_WIDTH-2:0], ge};
    q_full    = neg_q_q ? -step_quo : step_quo;
    r_full    = neg_r_q ? -step_rem : step_rem;
    q_word    = neg_q_q ? -step_quo[WORD_WIDTH-1:0] : step_quo[WORD_WIDTH-1:0];
    r_word    = neg_r_q ? -step_rem[WORD_WIDTH-1:0] : step_rem[WORD_WIDTH-1:0];
    if (word_q) begin
      final_res = is_rem_q ? sext_word(r_word) : sext_word(q_word);
    end else begin
      final_res = is_rem_q ? r_full : q_full;
    end
    cnt_last  = word_q ? CNT_W'(WORD_WIDTH - 1) : CNT_W'(DATA_WIDTH - 1);
  end

  // Next-state and datapath control
  always_comb begin : fsm_next
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    word_d   = word_q;
    is_rem_d = is_rem_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_start && op_c.valid && !i_flush) begin
          word_d   = op_c.word;
          is_rem_d = op_c.rem;
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          quo_d    = load_quo;
          rem_d    = '0;
          dvs_d    = load_dvs;
          cnt_d    = '0;
          if (div_zero || ovf) begin
            state_d  = ST_DONE;
            result_d = special_res;
            done_d   = 1'b1;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        quo_d = step_quo;
        rem_d = step_rem;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == cnt_last) begin
          state_d  = ST_DONE;
          result_d = final_res;
          done_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Flush wins over everything, including a same-cycle start
    if (i_flush) begin
      state_d  = ST_IDLE;
      done_d   = 1'b0;
      result_d = result_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_arst_n) begin : regs
    if (!i_arst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      word_q   <= 1'b0;
      is_rem_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      word_q   <= word_d;
      is_rem_q <= is_rem_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;

endmodule
